// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential fetch from a 1-cycle-latency instruction
// memory, stall hold, taken-bne redirect with a single squash bubble, and
// halt on WFI. instr is taken straight from the memory output (the memory
// holds its output while imem_rd_en is low), qualified by instr_valid.
module instr_fetch #(
  parameter int unsigned      dwidth_inst = 32,
  parameter int unsigned      PC_W        = 12,
  parameter logic [PC_W-1:0]  START_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ap_start,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [11:0]            branch_immediate,
  output logic [PC_W-1:0]        imem_addr,
  output logic                   imem_rd_en,
  input  logic [dwidth_inst-1:0] imem_rdata,
  output logic [dwidth_inst-1:0] instr,
  output logic                   instr_valid,
  output logic [PC_W-1:0]        pc,
  output logic                   busy,
  output logic                   halted
);

  localparam logic [dwidth_inst-1:0] WFI      = dwidth_inst'(32'h1050_0073);
  localparam logic [PC_W-1:0]        ALIGN    = ~PC_W'(3);
  localparam logic [PC_W-1:0]        START_AL = START_PC & ALIGN;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_f_q, pc_f_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic signed [12:0] br_off;
  logic [PC_W-1:0]   br_target;
  logic              is_wfi;

  // Branch offset is in half-words; sign-extend to PC_W and keep word alignment.
  assign br_off    = signed'({branch_immediate, 1'b0});
  assign br_target = pc_q + (PC_W'(br_off) & ALIGN);

  // Squash-slot data is never valid, so a WFI there can never trigger a halt.
  assign instr       = valid_q ? imem_rdata : '0;
  assign is_wfi      = valid_q && (imem_rdata == WFI);
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign imem_addr   = pc_f_q;
  assign busy        = (state_q == StRun);
  assign halted      = (state_q == StHalt);

  // State and fetch-pointer registers; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pc_f_q  <= START_AL;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_f_q  <= pc_f_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // Next-state, fetch sequencing and memory read enable.
  always_comb begin
    state_d    = state_q;
    pc_f_d     = pc_f_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    imem_rd_en = 1'b0;
    case (state_q)
      StIdle, StHalt: begin
        if (ap_start) begin
          pc_f_d  = START_AL;
          valid_d = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Stall freezes everything, including a pending branch decision.
        if (!stall) begin
          if (is_wfi) begin
            // No further fetch: the memory keeps presenting the WFI word.
            state_d = StHalt;
          end else begin
            imem_rd_en = 1'b1;
            pc_d       = pc_f_q;
            pc_f_d     = pc_f_q + PC_W'(4);
            valid_d    = 1'b1;
            if (valid_q && branch_taken) begin
              // The fetch issued this cycle becomes the bubble.
              pc_f_d  = br_target;
              valid_d = 1'b0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of expected (pc, instr)
// pairs consumed whenever the decoder accepts an instruction, plus per-task
// inline checks of control outputs.
module tb_instr_fetch;

  localparam logic [31:0] WFI = 32'h1050_0073;

  logic        clk;
  logic        rst;
  logic        ap_start, stall, branch_taken;
  logic [11:0] branch_immediate;
  logic [11:0] imem_addr, pc;
  logic        imem_rd_en, instr_valid, busy, halted;
  logic [31:0] imem_rdata, instr;

  logic        w_ap_start;
  logic [11:0] w_imem_addr, w_pc;
  logic        w_imem_rd_en, w_instr_valid, w_busy, w_halted;
  logic [31:0] w_imem_rdata, w_instr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [11:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb_q[$];

  instr_fetch u_dut (
    .clk(clk), .rst(rst), .ap_start(ap_start), .stall(stall),
    .branch_taken(branch_taken), .branch_immediate(branch_immediate),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .busy(busy), .halted(halted)
  );

  instr_fetch #(.START_PC(12'hFFC)) u_wrap (
    .clk(clk), .rst(rst), .ap_start(w_ap_start), .stall(1'b0),
    .branch_taken(1'b0), .branch_immediate(12'h000),
    .imem_addr(w_imem_addr), .imem_rd_en(w_imem_rd_en), .imem_rdata(w_imem_rdata),
    .instr(w_instr), .instr_valid(w_instr_valid), .pc(w_pc), .busy(w_busy),
    .halted(w_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: WFI at byte 20, otherwise a tagged word per address.
  function automatic logic [31:0] word_at(input logic [11:0] a);
    if (a == 12'd20) return WFI;
    return 32'hA000_0000 | {20'h0, a};
  endfunction

  // Instruction memory models: one-cycle read latency, output held when idle.
  always @(posedge clk) if (imem_rd_en) imem_rdata <= word_at(imem_addr);
  always @(posedge clk) if (w_imem_rd_en) w_imem_rdata <= word_at(w_imem_addr);

  task automatic push_exp(input logic [11:0] a);
    exp_t e;
    e.pc  = a;
    e.ins = word_at(a);
    sb_q.push_back(e);
  endtask

  // Scoreboard: an instruction is consumed when valid, not stalled, not halted.
  always @(negedge clk) begin
    if (rst && instr_valid && !stall && !halted) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got pc=%h instr=%h required none", pc, instr);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (pc !== e.pc || instr !== e.ins) begin
          errors++;
          $display("FAIL sb_instr got pc=%h instr=%h required pc=%h instr=%h",
                   pc, instr, e.pc, e.ins);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got=%b required=0", imem_rd_en); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b required=0", instr_valid); end
    checks++; if (busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rst_flags got=%b%b required=00", busy, halted); end
    checks++; if (pc !== 12'd0 || instr !== 32'd0) begin errors++; $display("FAIL rst_pc_instr got=%h/%h required=0/0", pc, instr); end
    checks++; if (imem_addr !== 12'd0) begin errors++; $display("FAIL rst_addr got=%h required=0", imem_addr); end
    tick(); rst = 1'b1;
    tick(); tick(); #1;
    checks++; if (busy !== 1'b0 || imem_rd_en !== 1'b0) begin errors++; $display("FAIL idle_hold got=%b%b required=00", busy, imem_rd_en); end
  endtask

  task automatic test_sequential();
    tick(); ap_start = 1'b1;
    push_exp(12'd0); push_exp(12'd4);
    tick(); ap_start = 1'b0; #1;
    checks++; if (busy !== 1'b1 || imem_rd_en !== 1'b1) begin errors++; $display("FAIL seq_start got=%b%b required=11", busy, imem_rd_en); end
    checks++; if (imem_addr !== 12'd0 || instr_valid !== 1'b0) begin errors++; $display("FAIL seq_first got addr=%h v=%b required 0/0", imem_addr, instr_valid); end
    tick(); #1;
    checks++; if (instr_valid !== 1'b1 || pc !== 12'd0 || imem_addr !== 12'd4) begin errors++; $display("FAIL seq_c1 got v=%b pc=%h addr=%h required 1/0/4", instr_valid, pc, imem_addr); end
    tick(); #1;
    checks++; if (pc !== 12'd4 || imem_addr !== 12'd8) begin errors++; $display("FAIL seq_c2 got pc=%h addr=%h required 4/8", pc, imem_addr); end
  endtask

  task automatic test_stall();
    push_exp(12'd8); push_exp(12'd12);
    // Branch held high under stall must be ignored.
    tick(); stall = 1'b1; branch_taken = 1'b1; branch_immediate = 12'hFF0; #1;
    checks++; if (imem_rd_en !== 1'b0 || pc !== 12'd8 || instr_valid !== 1'b1) begin errors++; $display("FAIL stall_c0 got rd=%b pc=%h v=%b required 0/8/1", imem_rd_en, pc, instr_valid); end
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      checks++; if (imem_rd_en !== 1'b0 || pc !== 12'd8 || instr !== word_at(12'd8) || instr_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got rd=%b pc=%h instr=%h required 0/8/%h", imem_rd_en, pc, instr, word_at(12'd8)); end
    end
    tick(); stall = 1'b0; branch_taken = 1'b0; #1;
    checks++; if (imem_rd_en !== 1'b1 || pc !== 12'd8 || imem_addr !== 12'd12) begin errors++; $display("FAIL stall_drop got rd=%b pc=%h addr=%h required 1/8/c", imem_rd_en, pc, imem_addr); end
    tick(); #1;
    checks++; if (pc !== 12'd12) begin errors++; $display("FAIL stall_next got pc=%h required=c", pc); end
  endtask

  task automatic test_branch();
    push_exp(12'd16); push_exp(12'd8); push_exp(12'd12); push_exp(12'd16); push_exp(12'd20);
    tick(); #1;
    checks++; if (pc !== 12'd16) begin errors++; $display("FAIL br_at got pc=%h required=10", pc); end
    branch_taken = 1'b1; branch_immediate = 12'hFFC;
    // Squash slot (holds the WFI word at 20); branch still high but must be ignored.
    tick(); #1;
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL br_bubble got v=%b busy=%b halt=%b required 0/1/0", instr_valid, busy, halted); end
    checks++; if (imem_addr !== 12'd8 || imem_rd_en !== 1'b1) begin errors++; $display("FAIL br_target got addr=%h rd=%b required 8/1", imem_addr, imem_rd_en); end
    tick(); branch_taken = 1'b0; #1;
    checks++; if (instr_valid !== 1'b1 || pc !== 12'd8) begin errors++; $display("FAIL br_land got v=%b pc=%h required 1/8", instr_valid, pc); end
    tick(); #1;
    checks++; if (pc !== 12'd12) begin errors++; $display("FAIL br_after got pc=%h required=c", pc); end
    tick(); #1;
  endtask

  task automatic test_wfi();
    tick(); #1;
    checks++; if (pc !== 12'd20 || instr !== WFI || imem_rd_en !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL wfi_seen got pc=%h instr=%h rd=%b halt=%b required 14/%h/0/0", pc, instr, imem_rd_en, halted, WFI); end
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checks++; if (halted !== 1'b1 || busy !== 1'b0 || imem_rd_en !== 1'b0 || instr_valid !== 1'b1 || instr !== WFI || pc !== 12'd20) begin errors++; $display("FAIL wfi_halt got halt=%b busy=%b rd=%b v=%b instr=%h pc=%h", halted, busy, imem_rd_en, instr_valid, instr, pc); end
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL wfi_drain got %0d left required 0", sb_q.size()); end
  endtask

  task automatic test_restart();
    push_exp(12'd0); push_exp(12'd4);
    ap_start = 1'b1;
    tick(); ap_start = 1'b0; #1;
    checks++; if (halted !== 1'b0 || busy !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 12'd0 || imem_rd_en !== 1'b1) begin errors++; $display("FAIL restart got halt=%b busy=%b v=%b addr=%h rd=%b", halted, busy, instr_valid, imem_addr, imem_rd_en); end
    tick(); #1;
    checks++; if (pc !== 12'd0 || instr_valid !== 1'b1) begin errors++; $display("FAIL restart_pc got pc=%h v=%b required 0/1", pc, instr_valid); end
    tick(); #1;
  endtask

  task automatic test_async_reset();
    tick(); #1;
    rst = 1'b0; #1;
    checks++; if (instr_valid !== 1'b0 || imem_rd_en !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL arst_ctrl got v=%b rd=%b busy=%b halt=%b required 0000", instr_valid, imem_rd_en, busy, halted); end
    checks++; if (pc !== 12'd0 || instr !== 32'd0 || imem_addr !== 12'd0) begin errors++; $display("FAIL arst_data got pc=%h instr=%h addr=%h required 0/0/0", pc, instr, imem_addr); end
    tick(); tick(); rst = 1'b1;
    tick(); tick(); #1;
    checks++; if (busy !== 1'b0 || imem_rd_en !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL arst_idle got busy=%b rd=%b v=%b required 000", busy, imem_rd_en, instr_valid); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL arst_drain got %0d left required 0", sb_q.size()); end
  endtask

  task automatic test_wrap();
    checks++; if (w_imem_addr !== 12'hFFC || w_busy !== 1'b0) begin errors++; $display("FAIL wrap_idle got addr=%h busy=%b required ffc/0", w_imem_addr, w_busy); end
    tick(); w_ap_start = 1'b1;
    tick(); w_ap_start = 1'b0; #1;
    checks++; if (w_imem_addr !== 12'hFFC || w_imem_rd_en !== 1'b1) begin errors++; $display("FAIL wrap_first got addr=%h rd=%b required ffc/1", w_imem_addr, w_imem_rd_en); end
    tick(); #1;
    checks++; if (w_imem_addr !== 12'h000 || w_pc !== 12'hFFC || w_instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_addr got addr=%h pc=%h v=%b required 0/ffc/1", w_imem_addr, w_pc, w_instr_valid); end
    tick(); #1;
    checks++; if (w_pc !== 12'h000 || w_instr !== word_at(12'h000)) begin errors++; $display("FAIL wrap_pc got pc=%h instr=%h required 0/%h", w_pc, w_instr, word_at(12'h000)); end
  endtask

  initial begin
    rst = 1'b0; ap_start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_immediate = 12'h000; w_ap_start = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_wfi();
    test_restart();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
- REQ-001: Parameter dwidth_inst, default 32, instruction word width.
- REQ-002: Parameter PC_W, default 12, byte-address width of instruction memory (word-aligned, 2^(PC_W-2) words).
- REQ-003: Parameter START_PC, default 0, fetch address loaded on ap_start.
- REQ-004: clk  input  1  single clock; all state updates on rising edge.
- REQ-005: rst  input  1  asynchronous, active-low reset (asserted when 0).
- REQ-006: ap_start  input  1  level; launches program execution from IDLE or HALT.
- REQ-007: stall  input  1  downstream decoder/datapath cannot accept a new instruction this cycle.
- REQ-008: branch_taken  input  1  resolved bne taken for the instruction currently presented.
- REQ-009: branch_immediate  input  12  bne offset field from the decoder, in half-words (target = pc + sext({imm,1'b0})).
- REQ-010: imem_addr  output  PC_W  byte address to instruction memory.
- REQ-011: imem_rd_en  output  1  memory read enable; memory returns data one cycle later and holds its output while imem_rd_en is 0.
- REQ-012: imem_rdata  input  dwidth_inst  instruction word from memory.
- REQ-013: instr  output  dwidth_inst  instruction presented to the decoder.
- REQ-014: instr_valid  output  1  instr is a live instruction.
- REQ-015: pc  output  PC_W  byte address of instr.
- REQ-016: busy  output  1  high in RUN.
- REQ-017: halted  output  1  high in HALT.

Function
- REQ-018: FSM states IDLE, RUN, HALT; reset state IDLE.
- REQ-019: IDLE: imem_rd_en=0, instr_valid=0; ap_start=1 -> pc_f<=START_PC, go RUN.
- REQ-020: RUN, stall=0, no redirect: imem_addr=pc_f, imem_rd_en=1, pc_f<=pc_f+4, pc<=pc_f, instr_valid<=1 next cycle; instr follows imem_rdata.
- REQ-021: First valid instruction appears exactly 2 cycles after ap_start sampled high; thereafter throughput 1 instruction/cycle.
- REQ-022: RUN, stall=1: imem_rd_en=0; pc_f, pc, instr, instr_valid held unchanged.
- REQ-023: branch_taken sampled only when instr_valid=1 and stall=0; otherwise ignored.
- REQ-024: On taken branch: pc_f<=pc+sext({branch_immediate,1'b0}) truncated to PC_W; the instruction fetched in the same cycle is squashed (instr_valid=0 for exactly 1 cycle); target instruction valid 2 cycles after branch sampled.
- REQ-025: branch_taken and stall both 1: stall wins; branch re-evaluated when stall drops.
- REQ-026: PC arithmetic wraps modulo 2^PC_W; bits [1:0] of pc_f always 0.
- REQ-027: When instr_valid=1 and instr equals WFI (32'h10500073) and stall=0: go HALT; no further fetches issued; in-flight fetch discarded.
- REQ-028: HALT: instr and pc hold the WFI word and its address, instr_valid stays 1 (decoder keeps seeing WFI for ap_done), imem_rd_en=0, halted=1.
- REQ-029: HALT with ap_start=1: restart as in REQ-019 (pc_f<=START_PC, instr_valid<=0, go RUN).
- REQ-030: WFI fetched in the squash slot of a taken branch is ignored.

Reset
- REQ-031: rst=0 immediately (asynchronously) forces IDLE, pc_f=START_PC, pc=0, instr=0, instr_valid=0, imem_rd_en=0, busy=0, halted=0.
- REQ-032: Reset mid-RUN or mid-stall discards all state; after rst=1, block stays IDLE until ap_start.

Verification
- REQ-033: Reset, ap_start pulse, stall=0 -> imem_addr 0,4,8,...; instr_valid rises 2 cycles after ap_start with pc=0, then pc=4,8 on consecutive cycles.
- REQ-034: stall=1 for 3 cycles while pc=8 -> pc=8, instr, instr_valid held, imem_rd_en=0; pc=12 one cycle after stall drops.
- REQ-035: bne at pc=16, branch_taken=1, branch_immediate=12'hFFC (-8 bytes) -> one bubble, next valid pc=8, then 12.
- REQ-036: WFI at pc=20 -> halted=1, instr=32'h10500073 held, imem_rd_en=0; ap_start -> fetch restarts at 0.
- REQ-037: rst=0 asserted mid-cycle during RUN -> outputs reach reset values without a clock edge; pc_f=0x FFC +4 wrap check: START_PC=0xFFC, PC_W=12 -> next pc=0.
